instr_fetch: RTL and testbench

Instruction-fetch stage directly upstream of the decode/control stage. Holds the program counter and issues sequential word fetches to instruction memory over a valid/ready request channel with in-order responses. Buffers returned instructions in a small FIFO. Presents the head instruction, its PC and pre-sliced fields (opcode, funct3, funct7, rd, rs1, rs2) to the decode/control stage over a valid/ready handshake. A redirect input (branch/jump) flushes buffered and in-flight fetches and restarts at a new PC.

---
 rtl/rv_pkg.sv | 30 +++
 rtl/fetch_fifo.sv | 59 +++++
 rtl/instr_fetch.sv | 133 +++++++++++++
 tb/tb_instr_fetch.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared RISC-V constants: datapath width, instruction field positions and major opcodes.
// The decode/control stage imports the same package so both stages agree on field slicing.
package rv_pkg;

  localparam int XLEN = 32;

  localparam int OPCODE_LSB = 0;
  localparam int OPCODE_MSB = 6;
  localparam int RD_LSB     = 7;
  localparam int RD_MSB     = 11;
  localparam int FUNCT3_LSB = 12;
  localparam int FUNCT3_MSB = 14;
  localparam int RS1_LSB    = 15;
  localparam int RS1_MSB    = 19;
  localparam int RS2_LSB    = 20;
  localparam int RS2_MSB    = 24;
  localparam int FUNCT7_LSB = 25;
  localparam int FUNCT7_MSB = 31;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding {instr, pc} pairs between the memory response and decode.
// Flush clears everything, including an entry popped in the same cycle.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty     = (r_count == '0);
  assign full      = (r_count == (AW+1)'(DEPTH));
  assign count     = r_count;
  assign head_data = r_mem[r_rd_ptr];
  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= push_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: PC sequencing, credit-limited memory requests, response buffering and
// redirect handling with exact discard of stale in-flight responses.
module instr_fetch #(
  parameter int                  XLEN     = rv_pkg::XLEN,
  parameter logic [XLEN-1:0]     RESET_PC = '0,
  parameter int                  DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic [6:0]      opcode,
  output logic [4:0]      rd,
  output logic [2:0]      funct3,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [6:0]      funct7
);

  import rv_pkg::*;

  // Handshake rule for both channels: a transfer happens on a rising edge where valid and
  // ready are both high; the request address holds while valid is high and not yet accepted.
  localparam int             CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0]    DEPTH_W = (CW+1)'(DEPTH);

  logic [XLEN-1:0]   r_pc;
  logic [XLEN-1:0]   r_rsp_pc;
  logic [CW-1:0]     r_inflight;
  logic [CW-1:0]     r_drop_cnt;

  logic [CW-1:0]     w_fifo_count;
  logic              w_full;
  logic              w_empty;
  logic [2*XLEN-1:0] w_head;
  logic              w_credit_ok;
  logic              w_req_fire;
  logic              w_drop_pending;
  logic              w_push;
  logic              w_pop;
  logic [XLEN-1:0]   w_redirect_pc;
  logic [CW-1:0]     w_inflight_next;
  logic [CW-1:0]     w_drop_next;
  logic              w_unused;

  // Low address bits of a redirect target are don't-care; fetches are always word aligned.
  assign w_redirect_pc = {redirect_pc[XLEN-1:2], 2'b00};
  assign w_unused      = ^redirect_pc[1:0];

  assign w_credit_ok    = ({1'b0, r_inflight} + {1'b0, w_fifo_count}) < DEPTH_W;
  assign imem_req_valid = rst_n & ~redirect_valid & w_credit_ok;
  assign imem_req_addr  = r_pc;
  assign w_req_fire     = imem_req_valid & imem_req_ready;
  assign w_drop_pending = (r_drop_cnt != '0);
  assign w_push         = imem_rsp_valid & ~redirect_valid & ~w_drop_pending;
  assign w_pop          = id_valid & id_ready;

  always_comb begin
    w_inflight_next = r_inflight;
    case ({w_req_fire, imem_rsp_valid})
      2'b10:   w_inflight_next = r_inflight + CW'(1);
      2'b01:   w_inflight_next = r_inflight - CW'(1);
      default: w_inflight_next = r_inflight;
    endcase
  end

  // Every request still unanswered after a redirect returns stale data and must be dropped.
  always_comb begin
    w_drop_next = r_drop_cnt;
    if (redirect_valid)
      w_drop_next = r_inflight - CW'(imem_rsp_valid);
    else if (imem_rsp_valid && w_drop_pending)
      w_drop_next = r_drop_cnt - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc       <= RESET_PC;
      r_rsp_pc   <= RESET_PC;
      r_inflight <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_inflight <= w_inflight_next;
      r_drop_cnt <= w_drop_next;
      if (redirect_valid) begin
        r_pc     <= w_redirect_pc;
        r_rsp_pc <= w_redirect_pc;
      end else begin
        if (w_req_fire) r_pc     <= r_pc + XLEN'(4);
        if (w_push)     r_rsp_pc <= r_rsp_pc + XLEN'(4);
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (2*XLEN)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push),
    .push_data ({imem_rsp_data, r_rsp_pc}),
    .pop       (w_pop),
    .flush     (redirect_valid),
    .head_data (w_head),
    .count     (w_fifo_count),
    .full      (w_full),
    .empty     (w_empty)
  );

  assign id_valid = ~w_empty;
  assign id_instr = w_head[2*XLEN-1:XLEN];
  assign id_pc    = w_head[XLEN-1:0];
  assign opcode   = id_instr[OPCODE_MSB:OPCODE_LSB];
  assign rd       = id_instr[RD_MSB:RD_LSB];
  assign funct3   = id_instr[FUNCT3_MSB:FUNCT3_LSB];
  assign rs1      = id_instr[RS1_MSB:RS1_LSB];
  assign rs2      = id_instr[RS2_MSB:RS2_LSB];
  assign funct7   = id_instr[FUNCT7_MSB:FUNCT7_LSB];

  // The credit rule keeps inflight + buffered <= DEPTH, so a push can never meet a full FIFO.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) w_push |-> !w_full);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: in-order memory model with settable latency, directed
// stimulus and hand-computed expected PCs, fields and request addresses.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [6:0]  funct7;

  always #5 clk = ~clk;

  instr_fetch #(.XLEN(32), .RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc),
    .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2), .funct7(funct7)
  );

  typedef struct { logic [31:0] addr; int due; } pend_t;
  pend_t       pend_q[$];
  logic [31:0] req_log[$];
  int          cyc = 0;
  int          rsp_lat = 1;
  int          n_total = 0;
  int          n_bad = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0050_0093;
      32'h4:   return 32'h0010_8133;
      default: return 32'hA500_0000 ^ a;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // One clock: log any accepted request, advance, then present the next in-order response.
  task automatic tick();
    #1;
    if (imem_req_valid && imem_req_ready) begin
      pend_q.push_back('{imem_req_addr, cyc + rsp_lat});
      req_log.push_back(imem_req_addr);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (!rst_n) begin
      pend_q.delete();
      imem_rsp_valid = 1'b0;
    end else if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(pend_q[0].addr);
      void'(pend_q.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    #1;
  endtask

  task automatic wait_head(input string tag, input logic [31:0] exp_pc);
    bit found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (id_valid) found = 1;
    end
    check({tag, "_seen"}, {31'd0, found}, 32'd1);
    if (found) begin
      check({tag, "_pc"}, id_pc, exp_pc);
      check({tag, "_instr"}, id_instr, mem_word(exp_pc));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int n0;
    @(negedge clk);
    rst_n = 1'b0;
    tick();
    tick();
    check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check("rst_id_valid", {31'd0, id_valid}, 32'd0);
    check("rst_id_instr", id_instr, 32'd0);
    check("rst_id_pc", id_pc, 32'd0);
    check("rst_opcode", {25'd0, opcode}, 32'd0);

    // Basic fetch and field slicing.
    rst_n = 1'b1; imem_req_ready = 1'b1; id_ready = 1'b1;
    #1;
    check("rel_req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("rel_req_addr", imem_req_addr, 32'h0);
    tick();
    check("req0_addr", req_log[0], 32'h0);
    tick();
    check("req1_addr", req_log[1], 32'h4);
    check("h0_valid", {31'd0, id_valid}, 32'd1);
    check("h0_pc", id_pc, 32'h0);
    check("h0_opcode", {25'd0, opcode}, 32'h13);
    check("h0_funct3", {29'd0, funct3}, 32'd0);
    check("h0_rd", {27'd0, rd}, 32'd1);
    check("h0_rs1", {27'd0, rs1}, 32'd0);
    check("h0_rs2", {27'd0, rs2}, 32'd5);

    // Stall the memory for 3 cycles with the next request pending at 0x8.
    imem_req_ready = 1'b0;
    tick();
    check("h1_pc", id_pc, 32'h4);
    check("h1_opcode", {25'd0, opcode}, 32'h33);
    check("h1_rd", {27'd0, rd}, 32'd2);
    check("h1_rs1", {27'd0, rs1}, 32'd1);
    check("h1_rs2", {27'd0, rs2}, 32'd1);
    check("h1_funct7", {25'd0, funct7}, 32'd0);
    check("stall0_addr", imem_req_addr, 32'h8);
    tick();
    check("stall1_addr", imem_req_addr, 32'h8);
    check("stall1_valid", {31'd0, imem_req_valid}, 32'd1);
    check("drained_id_valid", {31'd0, id_valid}, 32'd0);
    tick();
    check("stall2_addr", imem_req_addr, 32'h8);

    // Decode stalled: credits allow exactly DEPTH requests.
    imem_req_ready = 1'b1; id_ready = 1'b0;
    n0 = req_log.size();
    for (int i = 0; i < 10; i++) tick();
    check("credit_reqs", req_log.size() - n0, 32'd4);
    check("credit_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check("credit_first_addr", req_log[n0], 32'h8);
    imem_req_ready = 1'b0; id_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_valid", {31'd0, id_valid}, 32'd1);
      check("drain_pc", id_pc, 32'h8 + 32'(4 * i));
      check("drain_instr", id_instr, mem_word(32'h8 + 32'(4 * i)));
      tick();
    end
    check("drain_empty", {31'd0, id_valid}, 32'd0);

    // Redirect with two requests in flight (3-cycle memory).
    rsp_lat = 3; imem_req_ready = 1'b1;
    n0 = req_log.size();
    tick();
    tick();
    check("rd_inflight_reqs", req_log.size() - n0, 32'd2);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0102;
    #1;
    check("rd_req_blocked", {31'd0, imem_req_valid}, 32'd0);
    tick();
    redirect_valid = 1'b0;
    #1;
    check("rd_next_addr", imem_req_addr, 32'h100);
    wait_head("rd_head", 32'h100);
    check("rd_first_req", req_log[n0 + 2], 32'h100);
    imem_req_ready = 1'b0;
    for (int i = 0; i < 12; i++) tick();

    // Redirect coinciding with a head transfer and a response arrival.
    rsp_lat = 1; imem_req_ready = 1'b1; id_ready = 1'b0;
    tick();
    tick();
    check("coinc_head_valid", {31'd0, id_valid}, 32'd1);
    redirect_valid = 1'b1; redirect_pc = 32'h200; id_ready = 1'b1;
    tick();
    redirect_valid = 1'b0;
    #1;
    check("coinc_flushed", {31'd0, id_valid}, 32'd0);
    check("coinc_addr", imem_req_addr, 32'h200);
    tick();
    tick();
    check("coinc_head_after", {31'd0, id_valid}, 32'd1);
    check("coinc_pc_after", id_pc, 32'h200);

    // Back-to-back redirects: the second target wins.
    redirect_valid = 1'b1; redirect_pc = 32'h300;
    tick();
    redirect_pc = 32'h406;
    tick();
    redirect_valid = 1'b0;
    wait_head("b2b_head", 32'h404);

    // Reset with three buffered entries.
    imem_req_ready = 1'b0; id_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    imem_req_ready = 1'b1; id_ready = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("pre_rst_valid", {31'd0, id_valid}, 32'd1);
    rst_n = 1'b0;
    tick();
    check("mid_rst_id_valid", {31'd0, id_valid}, 32'd0);
    check("mid_rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check("mid_rst_id_pc", id_pc, 32'd0);
    rst_n = 1'b1;
    #1;
    check("post_rst_addr", imem_req_addr, 32'h0);
    n0 = req_log.size();
    tick();
    check("post_rst_req", req_log[n0], 32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
